// File: rtl/local_bus_arbiter.sv
// Local bus arbiter: Zorro slave vs NCR DMA, with Zorro III mastership sequencing.
// Optional DMA watchdog enabled by defining DMA_WATCHDOG_EN.
module local_bus_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int MAX_DMA_CYCLES = 64,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK_50M,
  input  logic       IORST_n,
  input  logic       slave_req,
  input  logic       slave_done,
  output logic       slave_gnt,
  input  logic       SBR_n,
  output logic       SBG_n,
  input  logic       MASTER_n,
  output logic       zbr_n,
  input  logic       zbg_n,
  input  logic       zfcs_n,
  input  logic       dma_cycle_end,
  output logic       dma_abort,
  output logic       bmaster,
  output logic       mybus_n,
  output logic [1:0] owner,
  output logic       wd_fired
);
  typedef enum logic [2:0] {
    IDLE, SLAVE, ZREQ, LGNT, DMA, DRAIN, RELEASE, HOLDOFF
  } state_t;

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [6:0] QMAX = 7'(MAX_DMA_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF_CYCLES - 1);

  state_t state, nxt, ret;
  logic [3:0] sync_q [SYNC_STAGES];
  logic sbr_s, master_s, zbg_s, zfcs_s;
  logic [6:0] cnt, cnt_nx;
  logic [HW-1:0] hcnt;
  logic quota_q, abort_q, quota_hit, wd_to;
  logic gnt_d, sbg_d, zbr_d, bm_d, mybus_d, abort_d;
  logic [1:0] owner_d;

  assign {sbr_s, master_s, zbg_s, zfcs_s} = sync_q[SYNC_STAGES-1];
  assign cnt_nx = cnt + 7'(dma_cycle_end);
  assign quota_hit = cnt_nx >= QMAX;

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {SBR_n, MASTER_n, zbg_n, zfcs_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      state     <= IDLE;
      ret       <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      quota_q   <= 1'b0;
      abort_q   <= 1'b0;
      slave_gnt <= 1'b0;
      SBG_n     <= 1'b1;
      zbr_n     <= 1'b1;
      bmaster   <= 1'b0;
      mybus_n   <= 1'b1;
      dma_abort <= 1'b0;
      owner     <= 2'b00;
    end else begin
      state     <= nxt;
      slave_gnt <= gnt_d;
      SBG_n     <= sbg_d;
      zbr_n     <= zbr_d;
      bmaster   <= bm_d;
      mybus_n   <= mybus_d;
      dma_abort <= abort_d;
      owner     <= owner_d;
      if (nxt == SLAVE && state != SLAVE) ret <= state;
      if (state == LGNT) cnt <= '0;
      else if (state == DMA) cnt <= cnt_nx;
      if (state == RELEASE) hcnt <= '0;
      else if (state == HOLDOFF && nxt == HOLDOFF) hcnt <= hcnt + HW'(1);
      if (state == DMA && quota_hit) quota_q <= 1'b1;
      else if (state == IDLE) quota_q <= 1'b0;
      if (state == DMA && nxt == DRAIN) abort_q <= quota_hit || wd_to;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (slave_req) nxt = SLAVE;
               else if (!sbr_s) nxt = ZREQ;
      SLAVE:   if (slave_done) nxt = ret;
      ZREQ:    if (slave_req) nxt = SLAVE;
               else if (!zbg_s && zfcs_s) nxt = LGNT;
               else if (sbr_s) nxt = IDLE;
      LGNT:    if (!master_s) nxt = DMA;
               else if (wd_to) nxt = RELEASE;
      DMA:     if (quota_hit || sbr_s || wd_to) nxt = DRAIN;
      DRAIN:   if (master_s) nxt = RELEASE;
      RELEASE: nxt = quota_q ? HOLDOFF : IDLE;
      HOLDOFF: if (slave_req) nxt = SLAVE;
               else if (hcnt == HLAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    gnt_d   = nxt == SLAVE;
    zbr_d   = !(nxt == ZREQ ||
                (nxt == SLAVE &&
                 (state == SLAVE ? ret == ZREQ : state == ZREQ)));
    sbg_d   = !(nxt inside {LGNT, DMA, DRAIN});
    bm_d    = nxt inside {LGNT, DMA, DRAIN, RELEASE};
    mybus_d = !(nxt inside {DMA, DRAIN});
    abort_d = nxt == DRAIN &&
              (state == DRAIN ? abort_q : (quota_hit || wd_to));
    owner_d = 2'b00;
    if (nxt == SLAVE) owner_d = 2'b01;
    else if (nxt inside {LGNT, DMA, DRAIN}) owner_d = 2'b10;
    else if (nxt == RELEASE) owner_d = 2'b11;
  end

`ifdef DMA_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_cnt;

  assign wd_to = wd_cnt == WLAST &&
                 ((state == LGNT && master_s) ||
                  (state == DMA && !dma_cycle_end));

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      wd_cnt   <= '0;
      wd_fired <= 1'b0;
    end else begin
      if (nxt != state || dma_cycle_end) wd_cnt <= '0;
      else if (state == LGNT || state == DMA) wd_cnt <= wd_cnt + WW'(1);
      if (wd_to) wd_fired <= 1'b1;
    end
  end
`else
  assign wd_to    = 1'b0;
  assign wd_fired = 1'b0;
`endif
endmodule

// File: tb/tb_local_bus_arbiter.sv
// Directed/randomized bench for local_bus_arbiter with a counting reference model.
// Watchdog scenario is exercised when DMA_WATCHDOG_EN is defined.
module tb_local_bus_arbiter;
  localparam int SS   = 2;
  localparam int MAXC = 64;
  localparam int HOLD = 16;
  localparam int TMO  = 4096;
  localparam logic [8:0] RST_OUTS = 9'b0_1_1_0_1_0_00_0;

  logic CLK_50M = 1'b0;
  logic IORST_n;
  logic slave_req, slave_done, SBR_n, MASTER_n;
  logic zbg_n, zfcs_n, dma_cycle_end;
  logic slave_gnt, SBG_n, zbr_n, dma_abort;
  logic bmaster, mybus_n, wd_fired;
  logic [1:0] owner;
  int errs = 0;
  int checks = 0;
  int model_cnt = 0;

  always #10 CLK_50M = ~CLK_50M;

  local_bus_arbiter #(
    .SYNC_STAGES(SS), .MAX_DMA_CYCLES(MAXC),
    .HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK_50M(CLK_50M), .IORST_n(IORST_n),
    .slave_req(slave_req), .slave_done(slave_done),
    .slave_gnt(slave_gnt), .SBR_n(SBR_n), .SBG_n(SBG_n),
    .MASTER_n(MASTER_n), .zbr_n(zbr_n), .zbg_n(zbg_n),
    .zfcs_n(zfcs_n), .dma_cycle_end(dma_cycle_end),
    .dma_abort(dma_abort), .bmaster(bmaster),
    .mybus_n(mybus_n), .owner(owner), .wd_fired(wd_fired)
  );

  task automatic tick();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {slave_gnt, SBG_n, zbr_n, bmaster, mybus_n,
            dma_abort, owner, wd_fired};
  endfunction

  task automatic enter_dma();
    int k = 0;
    while (mybus_n !== 1'b0 && k < 60) begin
      tick();
      k++;
    end
    chk("enter_dma", {mybus_n, owner, slave_gnt}, 4'b0100);
    model_cnt = 0;
  endtask

  // Quota model: abort must appear exactly with the MAXC-th completed cycle.
  task automatic dma_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("abort_gap", {dma_abort, mybus_n}, 2'b00);
      end
      dma_cycle_end = 1'b1;
      tick();
      dma_cycle_end = 1'b0;
      model_cnt++;
      chk("abort_pulse", {15'd0, dma_abort},
          {15'd0, model_cnt >= MAXC});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int n;
    IORST_n = 1'b0;
    slave_req = 1'b0;
    slave_done = 1'b0;
    SBR_n = 1'b1;
    MASTER_n = 1'b1;
    zbg_n = 1'b1;
    zfcs_n = 1'b1;
    dma_cycle_end = 1'b0;
    #25;
    chk("reset_outs", {7'd0, outs()}, {7'd0, RST_OUTS});
    #10 IORST_n = 1'b1;
    tick();
    chk("idle_outs", {7'd0, outs()}, {7'd0, RST_OUTS});

    repeat (3) begin
      slave_req = 1'b1;
      tick();
      chk("slave_gnt", {slave_gnt, owner}, 3'b101);
      n = $urandom_range(0, 3);
      repeat (n) tick();
      chk("slave_hold", {slave_gnt, mybus_n}, 2'b11);
      slave_done = 1'b1;
      slave_req = 1'b0;
      tick();
      slave_done = 1'b0;
      chk("slave_end", {slave_gnt, owner}, 3'b000);
      repeat ($urandom_range(0, 2)) tick();
    end

    SBR_n = 1'b0;
    slave_req = 1'b1;
    tick();
    chk("simul_slave_first", {slave_gnt, zbr_n}, 2'b11);
    repeat (3) tick();
    chk("simul_hold", {slave_gnt, zbr_n}, 2'b11);
    slave_done = 1'b1;
    slave_req = 1'b0;
    tick();
    slave_done = 1'b0;
    k = 1;
    while (zbr_n !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    chk("simul_zreq_within", {15'd0, (k <= SS + 1 && zbr_n === 1'b0)}, 16'd1);

    slave_req = 1'b1;
    tick();
    chk("zreq_slave", {slave_gnt, zbr_n, bmaster}, 3'b100);
    slave_done = 1'b1;
    slave_req = 1'b0;
    tick();
    slave_done = 1'b0;
    chk("zreq_back", {slave_gnt, zbr_n}, 2'b00);

    zbg_n = 1'b0;
    k = 0;
    while (bmaster !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("grant_latency", 16'(k), 16'(SS + 1));
    chk("grant_sbg", {SBG_n, zbr_n}, 2'b01);

    MASTER_n = 1'b0;
    k = 0;
    while (mybus_n !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk("own_latency", 16'(k), 16'(SS + 1));
    chk("own_state", {owner, slave_gnt}, 3'b100);
    model_cnt = 0;
    dma_pulses($urandom_range(1, 40));
    SBR_n = 1'b1;
    repeat (SS + 2) tick();
    chk("drain_no_abort", {dma_abort, mybus_n, SBG_n}, 3'b000);
    MASTER_n = 1'b1;
    k = 0;
    while (SBG_n !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("release_latency", 16'(k), 16'(SS + 1));
    chk("release_state", {bmaster, mybus_n, owner}, 4'b1111);
    tick();
    chk("release_idle", {bmaster, owner, zbr_n}, 4'b0001);

    SBR_n = 1'b0;
    MASTER_n = 1'b0;
    enter_dma();
    dma_pulses(MAXC);
    chk("quota_abort", {dma_abort, mybus_n}, 2'b10);
    MASTER_n = 1'b1;
    k = 0;
    while (SBG_n !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("quota_release_latency", 16'(k), 16'(SS + 1));
    chk("quota_release_state", {bmaster, owner, dma_abort}, 4'b1110);
    tick();
    chk("quota_bm_drop", {bmaster, owner}, 3'b000);
    k = 0;
    while (zbr_n !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    chk("holdoff_len", 16'(k), 16'(HOLD + 1));

    MASTER_n = 1'b0;
    enter_dma();
    dma_pulses(30);
    #5 IORST_n = 1'b0;
    #1;
    chk("async_reset", {7'd0, outs()}, {7'd0, RST_OUTS});
    #10 IORST_n = 1'b1;
    enter_dma();
    dma_pulses(MAXC);
    MASTER_n = 1'b1;
    SBR_n = 1'b1;
    k = 0;
    while (!(bmaster === 1'b0 && owner === 2'b00) && k < 40) begin
      tick();
      k++;
    end
    chk("restart_released", {bmaster, owner, SBG_n, mybus_n}, 5'b00011);
    repeat (HOLD + 2) tick();

`ifdef DMA_WATCHDOG_EN
    SBR_n = 1'b0;
    k = 0;
    while (SBG_n !== 1'b0 && k < 50) begin
      tick();
      k++;
    end
    chk("wd_lgnt", {SBG_n, wd_fired}, 2'b00);
    k = 0;
    while (SBG_n !== 1'b1 && k < TMO + 50) begin
      tick();
      k++;
    end
    chk("wd_timeout", 16'(k), 16'(TMO));
    chk("wd_flag", {wd_fired, owner}, 3'b111);
    tick();
    chk("wd_idle", {owner, wd_fired}, 3'b001);
`else
    chk("wd_tied", {15'd0, wd_fired}, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
